// File: rtl/led_pwm_fader.sv
// rtl/led_pwm_fader.sv - PWM dimmer for five LEDs with optional duty ramping
//
// A prescaler divides clk into PWM ticks. An 8-bit PWM counter advances on
// each tick, so one PWM period spans 256 ticks. The duty level only changes
// at the period boundary: it moves toward the brightness-derived target,
// either by FADE_STEP per period (FADE_EN=1) or in one jump (FADE_EN=0).
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   led          per-LED enable (5 bits)
//   brightness   brightness level 0..3, mapped to target duty 0/64/128/255
//   led_out      registered PWM-gated LED drive
//   duty         currently applied duty level
//   fading       high while the applied duty differs from the target
//   period_start one-cycle pulse in the cycle after each period boundary

module led_pwm_fader #(
    parameter int PRESCALE  = 390,
    parameter int FADE_EN   = 1,
    parameter int FADE_STEP = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] led,
    input  logic [1:0] brightness,
    output logic [4:0] led_out,
    output logic [7:0] duty,
    output logic       fading,
    output logic       period_start
);

    // Bit 1 of the encoding marks a ramp in progress, so fading is a plain
    // flop bit rather than a decode of the state vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b10,
        DOWN = 2'b11
    } state_t;

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);
    localparam logic [8:0]  STEP      = 9'(FADE_STEP);

    logic [15:0] presc;
    logic [7:0]  pwm_cnt;
    state_t      state;
    state_t      next_state;

    logic        tick;
    logic        boundary;
    logic        pwm_on;
    logic [7:0]  target;
    logic [7:0]  next_duty;
    logic [8:0]  sum;
    logic [8:0]  diff;

    always_comb begin
        target = 8'd0;
        case (brightness)
            2'd0: target = 8'd0;
            2'd1: target = 8'd64;
            2'd2: target = 8'd128;
            2'd3: target = 8'd255;
            default: target = 8'd0;
        endcase
    end

    assign tick     = (presc == PRESC_MAX);
    assign boundary = tick && (pwm_cnt == 8'hFF);

    // Full scale stays lit across the whole period, including pwm_cnt==255.
    assign pwm_on = (duty == 8'hFF) || (pwm_cnt < duty);

    // The ramp direction is taken from the live target, so a reversal in the
    // middle of a ramp steps away from the current duty rather than snapping.
    // The 9-bit sum/difference keep the clamp free of 8-bit wrap.
    always_comb begin
        sum        = {1'b0, duty} + STEP;
        diff       = {1'b0, duty} - {1'b0, target};
        next_duty  = duty;
        next_state = IDLE;
        if (FADE_EN == 0) begin
            next_duty = target;
        end else if (duty < target) begin
            next_duty = (sum >= {1'b0, target}) ? target : sum[7:0];
        end else if (duty > target) begin
            next_duty = (diff <= STEP) ? target : (duty - STEP[7:0]);
        end
        if (next_duty < target) begin
            next_state = UP;
        end else if (next_duty > target) begin
            next_state = DOWN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc        <= 16'd0;
            pwm_cnt      <= 8'd0;
            duty         <= 8'd0;
            state        <= IDLE;
            led_out      <= 5'd0;
            period_start <= 1'b0;
        end else begin
            presc        <= tick ? 16'd0 : (presc + 16'd1);
            period_start <= boundary;
            led_out      <= led & {5{pwm_on}};
            if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
            if (boundary) begin
                duty  <= next_duty;
                state <= next_state;
            end
        end
    end

    assign fading = state[1];

endmodule

// File: tb/tb_led_pwm_fader.sv
// tb/tb_led_pwm_fader.sv - directed bench for led_pwm_fader, jump and fade builds
module tb_led_pwm_fader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] led0, led1;
    logic [1:0] bri0, bri1;
    logic [4:0] led_out0, led_out1;
    logic [7:0] duty0, duty1;
    logic       fading0, fading1;
    logic       pstart0, pstart1;

    always #5 clk = ~clk;

    led_pwm_fader #(.PRESCALE(1), .FADE_EN(0), .FADE_STEP(16)) u_jump (
        .clk(clk), .rst_n(rst_n), .led(led0), .brightness(bri0),
        .led_out(led_out0), .duty(duty0), .fading(fading0), .period_start(pstart0)
    );

    led_pwm_fader #(.PRESCALE(1), .FADE_EN(1), .FADE_STEP(16)) u_fade (
        .clk(clk), .rst_n(rst_n), .led(led1), .brightness(bri1),
        .led_out(led_out1), .duty(duty1), .fading(fading1), .period_start(pstart1)
    );

    // One record per PWM period: inputs for both builds and the duty/fading
    // expected right after that period's boundary.
    typedef struct {
        logic [1:0] bri1;
        logic [4:0] led1;
        logic [7:0] exp_d1;
        logic       exp_f1;
        logic [1:0] bri0;
        logic [7:0] exp_d0;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   prev_d0 = 0;
    int   prev_d1 = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] b1, input logic [4:0] l1, input logic [7:0] d1,
                       input logic f1, input logic [1:0] b0, input logic [7:0] d0);
        vec_t v;
        v.bri1 = b1; v.led1 = l1; v.exp_d1 = d1; v.exp_f1 = f1;
        v.bri0 = b0; v.exp_d0 = d0;
        tbl.push_back(v);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Lit cycles in a period whose duty was d throughout.
    function automatic int exp_on(input int l, input int d);
        if (l == 0) return 0;
        return (d == 255) ? 256 : d;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, " led_out_jump"}, int'(led_out0), 0);
        chk({tag, " duty_jump"},    int'(duty0),    0);
        chk({tag, " fading_jump"},  int'(fading0),  0);
        chk({tag, " pstart_jump"},  int'(pstart0),  0);
        chk({tag, " led_out_fade"}, int'(led_out1), 0);
        chk({tag, " duty_fade"},    int'(duty1),    0);
        chk({tag, " fading_fade"},  int'(fading1),  0);
        chk({tag, " pstart_fade"},  int'(pstart1),  0);
    endtask

    // Runs one full period; brightness changes halfway through so that any
    // mid-period reaction of duty is caught by the stability counters.
    task automatic run_period(input int idx);
        vec_t v;
        int on0, on1, bad0, bad1, ps, dchg0, dchg1;
        v = tbl[idx];
        on0 = 0; on1 = 0; bad0 = 0; bad1 = 0; ps = 0; dchg0 = 0; dchg1 = 0;
        led1 = v.led1;
        for (int c = 1; c <= 256; c++) begin
            if (c == 129) begin
                bri1 = v.bri1;
                bri0 = v.bri0;
            end
            step(1);
            if (led_out0 != 5'd0) on0++;
            if (led_out1 != 5'd0) on1++;
            if (led_out0 != 5'd0 && led_out0 != led0) bad0++;
            if (led_out1 != 5'd0 && led_out1 != led1) bad1++;
            if (c < 256) begin
                if (pstart0) ps++;
                if (pstart1) ps++;
                if (int'(duty0) != prev_d0) dchg0++;
                if (int'(duty1) != prev_d1) dchg1++;
            end
        end
        chk($sformatf("p%0d duty_fade", idx),      int'(duty1),   int'(v.exp_d1));
        chk($sformatf("p%0d fading_fade", idx),    int'(fading1), int'(v.exp_f1));
        chk($sformatf("p%0d duty_jump", idx),      int'(duty0),   int'(v.exp_d0));
        chk($sformatf("p%0d fading_jump", idx),    int'(fading0), 0);
        chk($sformatf("p%0d pstart_fade", idx),    int'(pstart1), 1);
        chk($sformatf("p%0d pstart_jump", idx),    int'(pstart0), 1);
        chk($sformatf("p%0d early_pstart", idx),   ps, 0);
        chk($sformatf("p%0d midperiod_duty_fade", idx), dchg1, 0);
        chk($sformatf("p%0d midperiod_duty_jump", idx), dchg0, 0);
        chk($sformatf("p%0d lit_cycles_fade", idx), on1, exp_on(int'(led1), prev_d1));
        chk($sformatf("p%0d lit_cycles_jump", idx), on0, exp_on(int'(led0), prev_d0));
        chk($sformatf("p%0d bad_pattern", idx),     bad0 + bad1, 0);
        prev_d1 = int'(v.exp_d1);
        prev_d0 = int'(v.exp_d0);
    endtask

    initial begin
        rst_n = 1'b0;
        led0  = 5'b10101;
        led1  = 5'h1F;
        bri0  = 2'd2;
        bri1  = 2'd3;

        // Ramp 0 -> 255 in 16 boundaries, hold, then all LEDs disabled.
        for (int k = 1; k <= 15; k++) add(2'd3, 5'h1F, 8'(16 * k), 1'b1, 2'd2, 8'd128);
        add(2'd3, 5'h1F, 8'd255, 1'b0, 2'd3, 8'd255);
        add(2'd3, 5'h1F, 8'd255, 1'b0, 2'd0, 8'd0);
        add(2'd3, 5'h00, 8'd255, 1'b0, 2'd1, 8'd64);
        // Short ramp to 48 before the asynchronous reset.
        add(2'd3, 5'h1F, 8'd16,  1'b1, 2'd2, 8'd128);
        add(2'd3, 5'h1F, 8'd32,  1'b1, 2'd2, 8'd128);
        add(2'd3, 5'h1F, 8'd48,  1'b1, 2'd2, 8'd128);
        // Restart from 0, reverse at 96 toward brightness 1.
        add(2'd3, 5'h1F, 8'd16,  1'b1, 2'd2, 8'd128);
        add(2'd3, 5'h1F, 8'd32,  1'b1, 2'd2, 8'd128);
        add(2'd3, 5'h1F, 8'd48,  1'b1, 2'd2, 8'd128);
        add(2'd3, 5'h1F, 8'd64,  1'b1, 2'd2, 8'd128);
        add(2'd3, 5'h1F, 8'd80,  1'b1, 2'd0, 8'd0);
        add(2'd3, 5'h1F, 8'd96,  1'b1, 2'd0, 8'd0);
        add(2'd1, 5'h1F, 8'd80,  1'b1, 2'd3, 8'd255);
        add(2'd1, 5'h1F, 8'd64,  1'b0, 2'd3, 8'd255);
        add(2'd1, 5'h1F, 8'd64,  1'b0, 2'd1, 8'd64);

        #2;
        chk_zero("reset_before_clk");
        step(3);
        chk_zero("reset_held");

        rst_n = 1'b1;
        prev_d0 = 0; prev_d1 = 0;
        for (int i = 0; i <= 17; i++) run_period(i);

        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        prev_d0 = 0; prev_d1 = 0;
        for (int i = 18; i <= 20; i++) run_period(i);

        step(20);
        chk("pre_reset led_out_fade", int'(led_out1), 31);
        chk("pre_reset led_out_jump", int'(led_out0), 21);
        chk("pre_reset duty_fade",    int'(duty1),    48);
        chk("pre_reset fading_fade",  int'(fading1),  1);
        rst_n = 1'b0;
        #2;
        chk_zero("async_reset");
        step(3);
        chk_zero("async_reset_held");
        rst_n = 1'b1;
        prev_d0 = 0; prev_d1 = 0;
        for (int i = 21; i < tbl.size(); i++) run_period(i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pwm_fader.md
LED_PWM_FADER -- requirements
Module: led_pwm_fader

Interface
REQ-001 Parameter PRESCALE, default 390, clk cycles per PWM tick; legal range 1..65535.
REQ-002 Parameter FADE_EN, default 1, 1 = ramp duty toward target, 0 = jump to target.
REQ-003 Parameter FADE_STEP, default 16, duty change per PWM period while ramping; legal range 1..255.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 led  input  5  per-LED enable from the MMIO LED register, same clock domain.
REQ-007 brightness  input  2  brightness level from the MMIO brightness register, same clock domain.
REQ-008 led_out  output  5  registered PWM-gated LED drive to pins.
REQ-009 duty  output  8  current applied duty level.
REQ-010 fading  output  1  high while duty != target.
REQ-011 period_start  output  1  one-cycle pulse at each PWM period boundary.

Function
REQ-012 Target duty SHALL map from brightness: 0->0, 1->64, 2->128, 3->255.
REQ-013 Prescaler SHALL count 0..PRESCALE-1 and wrap; tick SHALL be asserted in the cycle the count equals PRESCALE-1.
REQ-014 pwm_cnt (8 bits) SHALL increment on each tick, wrapping 255->0.
REQ-015 Period boundary SHALL be defined as tick while pwm_cnt==255; period_start SHALL be registered high in the cycle after the boundary only.
REQ-016 duty and state SHALL change only at a period boundary; mid-period brightness changes SHALL have no effect until the next boundary.
REQ-017 States: IDLE (duty==target), UP (duty<target), DOWN (duty>target); state SHALL be re-evaluated at every boundary from the updated duty and the current target.
REQ-018 With FADE_EN=1 at a boundary: UP -> duty=min(duty+FADE_STEP, target); DOWN -> duty=max(duty-FADE_STEP, target); no overshoot, no 8-bit wrap.
REQ-019 With FADE_EN=0 at a boundary: duty SHALL load target directly.
REQ-020 Target reversal during ramp SHALL take effect at the next boundary, moving duty from its current value toward the new target.
REQ-021 pwm_on SHALL be 1 when duty==255, else (pwm_cnt < duty); duty 0 SHALL yield pwm_on=0 always.
REQ-022 led_out SHALL be registered as led & {5{pwm_on}}: latency 1 clk from led or pwm_cnt change.
REQ-023 fading SHALL be registered, equal to (state != IDLE) after each boundary update.

Reset
REQ-024 rst_n low SHALL immediately (asynchronously) clear prescaler, pwm_cnt, duty, led_out, fading, period_start to 0 and state to IDLE.
REQ-025 After rst_n deasserts, prescaler SHALL start from 0 on the first rising clk edge; first boundary SHALL occur 256*PRESCALE cycles later.

Verification (PRESCALE=1, FADE_STEP=16 unless stated)
REQ-026 Reset: rst_n=0 with led=5'h1F, brightness=3 -> led_out=0, duty=0, fading=0, period_start=0 while held.
REQ-027 FADE_EN=0, brightness=2, led=5'b10101 -> after first boundary duty=128; led_out=5'b10101 for 128 and 0 for 128 of each 256 cycles.
REQ-028 FADE_EN=1, brightness 0->3 -> duty 16,32,...,240,255 on 16 consecutive boundaries; fading high until duty=255 then low; led_out constant high at 255.
REQ-029 Reversal: ramping up at duty=96, brightness set to 1 -> next boundaries duty=80, then 64, then holds; fading low after 64.
REQ-030 led=0 with brightness=3 and duty=255 -> led_out=0 every cycle; period_start still pulses every 256 cycles.
REQ-031 rst_n pulsed low mid-ramp (duty=48, mid-period) -> outputs 0 without clock edge; ramp restarts from duty 0 after release.
